// File: rtl/rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp_engine
//  Purpose  : Computes result = base^exp mod n with a start/busy/done
//             handshake. Right-to-left square-and-multiply built on a
//             bit-serial interleaved modular multiplier (one multiplier bit
//             per cycle, WIDTH cycles per modular multiply). Reports the
//             number of busy cycles of each operation for timing analysis.
//  Build option:
//    RSA_CONST_TIME_EN - when defined, every operation runs all EXP_W loop
//                        iterations and always performs the multiply step,
//                        so latency does not depend on exp or base.
//  Ports:
//    clk, rst_n     clock (rising edge), asynchronous active-low reset
//    start          request, accepted when busy is low
//    base, exp, n   operands, captured on accept
//    busy           operation in progress
//    done           one-cycle completion pulse
//    result         base^exp mod n, held until the next done
//    err            pulses with done when n == 0
//    cycles         busy-cycle count of the last operation (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_engine #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 16,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // NEXT and FIN are decided combinationally on the last cycle of a
  // modular multiply, so the state register never rests in them.
  typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, NEXT, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [EXP_W-1:0] exp_q;
  logic [WIDTH-1:0] a_q;       // multiplicand of the running modmul
  logic [WIDTH-1:0] mul_q;     // multiplier, consumed MSB first
  logic [WIDTH+1:0] acc_q;     // holds values up to 3n-1 before correction
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cyc_q;

`ifdef RSA_CONST_TIME_EN
  localparam int IW = $clog2(EXP_W + 1);
  logic [IW-1:0]    iter_q;
  logic [WIDTH-1:0] dummy_q;   // sink for the multiply of a 0 exponent bit
`endif

  // ---------------- bit-serial modular multiply datapath ----------------
  logic [WIDTH+1:0] n_ext, t0, t1, t2;
  logic [WIDTH-1:0] prod;
  logic             last_bit;
  logic [CNT_W-1:0] cyc_inc;

  always_comb begin
    n_ext    = {2'b00, n_q};
    t0       = (acc_q << 1) + (mul_q[WIDTH-1] ? {2'b00, a_q} : '0);
    t1       = (t0 >= n_ext) ? (t0 - n_ext) : t0;
    t2       = (t1 >= n_ext) ? (t1 - n_ext) : t1;
    prod     = t2[WIDTH-1:0];
    last_bit = (bit_cnt == BCW'(WIDTH - 1));
    cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
  end

  // ---------------- loop sequencing (NEXT / FIN decisions) ----------------
  logic [EXP_W-1:0] exp_sh;
  logic [WIDTH-1:0] b_next, r_next;
  state_t           next_op;
  logic             finish;

  always_comb begin
    exp_sh  = exp_q >> 1;
    b_next  = (state == REDUCE || state == SQR) ? prod : b_q;
    r_next  = r_q;
    next_op = IDLE;
    finish  = 1'b0;
`ifdef RSA_CONST_TIME_EN
    if (state == MUL && exp_q[0]) r_next = prod;
    case (state)
      REDUCE:  next_op = MUL;
      MUL:     next_op = SQR;
      SQR: begin
        if (iter_q == IW'(EXP_W - 1)) finish = 1'b1;
        else                          next_op = MUL;
      end
      default: next_op = IDLE;
    endcase
`else
    if (state == MUL) r_next = prod;
    case (state)
      REDUCE: begin
        if (exp_q == '0) finish = 1'b1;
        else             next_op = exp_q[0] ? MUL : SQR;
      end
      MUL:     next_op = SQR;
      SQR: begin
        if (exp_sh == '0) finish = 1'b1;
        else              next_op = exp_sh[0] ? MUL : SQR;
      end
      default: next_op = IDLE;
    endcase
`endif
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_q     <= '0;
      exp_q   <= '0;
      a_q     <= '0;
      mul_q   <= '0;
      acc_q   <= '0;
      bit_cnt <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cyc_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
      cycles  <= '0;
`ifdef RSA_CONST_TIME_EN
      iter_q  <= '0;
      dummy_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            if (n == '0) begin
              // Degenerate modulus: report immediately, never go busy.
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
              cycles <= '0;
            end else begin
              n_q     <= n;
              exp_q   <= exp;
              a_q     <= WIDTH'(1);  // 1 * base, reduced bit by bit
              mul_q   <= base;
              acc_q   <= '0;
              bit_cnt <= '0;
              r_q     <= (n == WIDTH'(1)) ? '0 : WIDTH'(1);
              cyc_q   <= '0;
              busy    <= 1'b1;
              state   <= REDUCE;
`ifdef RSA_CONST_TIME_EN
              iter_q  <= '0;
`endif
            end
          end
        end
        REDUCE, MUL, SQR: begin
          cyc_q <= cyc_inc;
          if (!last_bit) begin
            acc_q   <= t2;
            mul_q   <= mul_q << 1;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            acc_q   <= '0;
            bit_cnt <= '0;
            b_q     <= b_next;
            r_q     <= r_next;
`ifdef RSA_CONST_TIME_EN
            if (state == MUL && !exp_q[0]) dummy_q <= prod;
            if (state == SQR) iter_q <= iter_q + 1'b1;
`endif
            if (state == SQR) exp_q <= exp_sh;
            if (finish) begin
              // Last op is REDUCE or SQR, neither of which touches r.
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= r_q;
              cycles <= cyc_inc;
            end else begin
              state <= next_op;
              a_q   <= (next_op == MUL) ? r_next : b_next;
              mul_q <= b_next;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
